// File: rtl/stack_param_if.sv
// Command/result bundle for stack_param: the master drives the command, index and push data,
// and the slave returns the registered read data, the entry count and the status flags.
interface stack_param_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5
);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [1:0]      command;
  logic [IDXW-1:0] index;
  logic [WIDTH-1:0] i_data;
  logic [WIDTH-1:0] o_data;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;
  logic            err;

  modport master (
    output command, index, i_data,
    input  o_data, count, full, empty, err
  );

  modport slave (
    input  command, index, i_data,
    output o_data, count, full, empty, err
  );
endinterface

// File: rtl/stack_param.sv
// LIFO stack on a DEPTH-entry circular buffer; PUSH/POP/GET take effect on one edge, and every output is registered.
// If STACK_PARAM_WRAP_EN is defined, a PUSH to a full stack overwrites the oldest word; otherwise the PUSH is dropped and ERR pulses.
module stack_param #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  stack_param_if.slave  bus
);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PTRW-1:0] LAST      = PTRW'(DEPTH - 1);
  localparam logic [PTRW:0]   DEPTH_EXT = (PTRW + 1)'(DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  top_q, top_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             err_q, err_d;
  logic             we;
  logic [PTRW-1:0]  top_inc, top_dec, get_addr;
  logic             full, empty, get_ok;
  cmd_e             cmd;

  assign cmd     = cmd_e'(bus.command);
  assign full    = (count_q == CNT_MAX);
  assign empty   = (count_q == '0);
  assign top_inc = (top_q == LAST) ? '0 : top_q + 1'b1;
  assign top_dec = (top_q == '0) ? LAST : top_q - 1'b1;
  assign get_ok  = (32'(bus.index) < 32'(count_q));

  // A legal GET index is below COUNT <= DEPTH, so a single DEPTH add folds the wrap.
  always_comb begin
    if ({1'b0, top_q} >= {1'b0, bus.index})
      get_addr = top_q - bus.index;
    else
      get_addr = PTRW'({1'b0, top_q} + DEPTH_EXT - {1'b0, bus.index});
  end

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    odata_d = odata_q;
    err_d   = 1'b0;
    we      = 1'b0;
    unique case (cmd)
      CMD_NOP: ;
      CMD_PUSH: begin
        if (!full) begin
          we      = 1'b1;
          top_d   = top_inc;
          count_d = count_q + 1'b1;
        end else begin
`ifdef STACK_PARAM_WRAP_EN
          we    = 1'b1;
          top_d = top_inc;
`else
          err_d = 1'b1;
`endif
        end
      end
      CMD_POP: begin
        if (!empty) begin
          odata_d = mem_q[top_q];
          top_d   = top_dec;
          count_d = count_q - 1'b1;
        end else begin
          odata_d = '0;
          err_d   = 1'b1;
        end
      end
      CMD_GET: begin
        if (get_ok) begin
          odata_d = mem_q[get_addr];
        end else begin
          odata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      top_q   <= '0;
      count_q <= '0;
      odata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      odata_q <= odata_d;
      err_q   <= err_d;
    end
  end

  // Storage is left uncleared; entries above COUNT are never read.
  always_ff @(posedge clk_i) begin
    if (we && !rst_i)
      mem_q[top_inc] <= bus.i_data;
  end

  assign bus.o_data = odata_q;
  assign bus.count  = count_q;
  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_stack_param.sv
// Directed bench for stack_param (WIDTH=4, DEPTH=5); the expected values follow STACK_PARAM_WRAP_EN.
module tb_stack_param;
  localparam int WIDTH = 4;
  localparam int DEPTH = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  stack_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) sif ();

  stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one command across one rising edge; returns on the following falling edge.
  task automatic do_cmd(input logic [1:0] cmd, input int idx, input int dat);
    sif.command = cmd;
    sif.index   = 3'(idx);
    sif.i_data  = 4'(dat);
    @(posedge clk);
    @(negedge clk);
    sif.command = 2'b00;
  endtask

  task automatic check_status(input string tag, input int cnt, input int od, input int er);
    check_eq({tag, ".count"}, 32'(sif.count), 32'(cnt));
    check_eq({tag, ".o_data"}, 32'(sif.o_data), 32'(od));
    check_eq({tag, ".err"}, 32'(sif.err), 32'(er));
  endtask

  initial begin
    int exp_top;
    int exp_pop [5];
    sif.command = 2'b00;
    sif.index   = '0;
    sif.i_data  = '0;

    // Reset takes effect with no clock edge.
    #2;
    check_status("reset", 0, 0, 0);
    check_eq("reset.empty", 32'(sif.empty), 32'd1);
    check_eq("reset.full", 32'(sif.full), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // POP on empty stack
    do_cmd(2'b10, 0, 0);
    check_status("pop_empty", 0, 0, 1);
    check_eq("pop_empty.empty", 32'(sif.empty), 32'd1);
    do_cmd(2'b00, 0, 0);
    check_eq("err_clears", 32'(sif.err), 32'd0);

    // Fill with 1..5
    for (int i = 1; i <= 5; i++) begin
      do_cmd(2'b01, 0, i);
      check_status($sformatf("push%0d", i), i, 0, 0);
    end
    check_eq("full_after_fill", 32'(sif.full), 32'd1);
    check_eq("empty_after_fill", 32'(sif.empty), 32'd0);

    for (int i = 0; i < 5; i++) begin
      do_cmd(2'b11, i, 0);
      check_status($sformatf("get%0d", i), 5, 5 - i, 0);
    end

    // PUSH 6 into a full stack
    do_cmd(2'b01, 0, 6);
`ifdef STACK_PARAM_WRAP_EN
    check_status("push_full", 5, 1, 0);
    exp_top = 6;
`else
    check_status("push_full", 5, 1, 1);
    exp_top = 5;
`endif
    do_cmd(2'b11, 0, 0);
    check_status("full_get0", 5, exp_top, 0);
    do_cmd(2'b11, 4, 0);
    check_status("full_get4", 5, exp_top - 4, 0);

    // Drain with five POPs, then one more
    for (int i = 0; i < 5; i++) exp_pop[i] = exp_top - i;
    for (int i = 0; i < 5; i++) begin
      do_cmd(2'b10, 0, 0);
      check_status($sformatf("pop%0d", i), 4 - i, exp_pop[i], 0);
    end
    check_eq("drained.empty", 32'(sif.empty), 32'd1);
    do_cmd(2'b10, 0, 0);
    check_status("pop_sixth", 0, 0, 1);

    // GET range checks
    do_cmd(2'b01, 0, 9);
    do_cmd(2'b01, 0, 10);
    check_status("push9_10", 2, 0, 0);
    do_cmd(2'b11, 3, 0);
    check_status("get3_oob", 2, 0, 1);
    do_cmd(2'b11, 1, 0);
    check_status("get1", 2, 9, 0);
    do_cmd(2'b11, 0, 0);
    check_status("get0", 2, 10, 0);
    do_cmd(2'b11, 7, 0);
    check_status("get7_oob", 2, 0, 1);
    do_cmd(2'b11, 2, 0);
    check_status("get2_eq_count", 2, 0, 1);

    // Reset between edges with COUNT=3
    do_cmd(2'b01, 0, 11);
    do_cmd(2'b11, 0, 0);
    check_status("pre_reset", 3, 11, 0);
    #2 rst = 1'b1;
    #1;
    check_status("mid_reset", 0, 0, 0);
    check_eq("mid_reset.empty", 32'(sif.empty), 32'd1);
    check_eq("mid_reset.full", 32'(sif.full), 32'd0);
    #1 rst = 1'b0;
    do_cmd(2'b11, 0, 0);
    check_status("get_after_reset", 0, 0, 1);
    do_cmd(2'b01, 0, 3);
    do_cmd(2'b11, 0, 0);
    check_status("push_after_reset", 1, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stack_param.md
STACK_PARAM -- requirements
Module: stack_param

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 5, stack capacity in words (>=2).
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  reset, asynchronous and active-high.
REQ-005 COMMAND  input  2  operation: 00 NOP, 01 PUSH, 10 POP, 11 GET.
REQ-006 INDEX  input  max(1,$clog2(DEPTH))  GET position counted from top; 0 = top.
REQ-007 I_DATA  input  WIDTH  word written on PUSH.
REQ-008 O_DATA  output  WIDTH  registered read result of POP/GET.
REQ-009 COUNT  output  $clog2(DEPTH+1)  number of valid entries.
REQ-010 FULL  output  1  high when COUNT == DEPTH.
REQ-011 EMPTY  output  1  high when COUNT == 0.
REQ-012 ERR  output  1  one-cycle pulse flagging an illegal operation.

Function
REQ-013 COMMAND, INDEX, I_DATA SHALL be sampled on the CLK rising edge; all outputs SHALL be registered, one-cycle latency.
REQ-014 Storage SHALL be a DEPTH-entry circular buffer with top pointer; pointer arithmetic wraps modulo DEPTH (non-power-of-two DEPTH supported).
REQ-015 NOP: storage, COUNT, O_DATA held; ERR=0.
REQ-016 PUSH not full: I_DATA written at top+1, top advances, COUNT+1; O_DATA held; ERR=0.
REQ-017 PUSH when FULL: behaviour per REQ-027/REQ-028.
REQ-018 POP not empty: O_DATA <= top word, top retreats, COUNT-1; ERR=0.
REQ-019 POP when EMPTY: O_DATA <= 0, COUNT stays 0, ERR=1 for one cycle.
REQ-020 GET with INDEX < COUNT: O_DATA <= word INDEX positions below top; no state change; ERR=0.
REQ-021 GET with INDEX >= COUNT (incl. INDEX >= DEPTH): O_DATA <= 0, ERR=1 for one cycle, no state change.
REQ-022 FULL/EMPTY SHALL be decoded from registered COUNT, valid in same cycle as COUNT.
REQ-023 ERR SHALL return to 0 on the next edge unless another illegal operation is sampled.

Reset
REQ-024 RESET high SHALL immediately, without a CLK edge, force COUNT=0, top pointer=0, O_DATA=0, ERR=0, FULL=0, EMPTY=1.
REQ-025 Storage contents need not be cleared; entries are unreachable until re-pushed.
REQ-026 Reset mid-operation SHALL abort the in-flight command; first command after RESET falls SHALL act on an empty stack.

Configuration
REQ-027 Macro STACK_PARAM_WRAP_EN defined: PUSH when FULL overwrites the oldest entry, top advances, COUNT stays DEPTH, ERR=0.
REQ-028 Macro STACK_PARAM_WRAP_EN undefined: PUSH when FULL is discarded, storage/top/COUNT unchanged, ERR=1 for one cycle.

Verification (WIDTH=4, DEPTH=5)
REQ-029 Reset, PUSH 1..5 -> COUNT=5, FULL=1; GET INDEX 0..4 -> O_DATA 5,4,3,2,1, ERR=0.
REQ-030 After reset, POP -> O_DATA=0, ERR pulse one cycle, COUNT=0, EMPTY=1.
REQ-031 Full with 1..5, PUSH 6 -> without macro ERR=1, GET 0 = 5, GET 4 = 1; with macro ERR=0, GET 0 = 6, GET 4 = 2.
REQ-032 PUSH 9, PUSH 10, GET INDEX=3 -> O_DATA=0, ERR=1, COUNT=2; GET INDEX=1 -> 9.
REQ-033 Full stack, 5 POPs -> O_DATA 5,4,3,2,1, COUNT 4..0, EMPTY=1 after last; sixth POP -> ERR=1.
REQ-034 RESET raised between CLK edges with COUNT=3 -> COUNT=0, O_DATA=0, EMPTY=1 before next edge; following GET 0 -> ERR=1.
